// File: rtl/squarer_seq.sv
// squarer_seq: sequential shift-and-add squarer.
// It takes an unsigned WIDTH-bit operand and returns its exact 2*WIDTH-bit square.
// A small control FSM (IDLE -> CALC -> DONE) drives a datapath made of an
// accumulator, a left-shifting multiplicand and a right-shifting multiplier.
//
// Optional feature: define SQUARER_EARLY_EXIT_EN to leave CALC as soon as no set
// bits remain in the shifted multiplier. Results are identical; only latency
// shrinks. Without the macro every operand takes WIDTH iterations plus one DONE
// cycle.
module squarer_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   valor_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] square_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic                 busy_r;
    logic                 ready_r;
    logic [2*WIDTH-1:0]   square_r;

    // Datapath registers; the accumulator never reaches the outputs directly,
    // so square_o only ever shows a finished product.
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [2*WIDTH-1:0]   acc_next_s;
    logic                 last_iter_s;

    // Partial-product add: the multiplicand joins the sum only when the current multiplier LSB is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Decide whether the iteration running this cycle is the final one.
    always_comb begin
        last_iter_s = 1'b0;
`ifdef SQUARER_EARLY_EXIT_EN
        // Once the bits still to be consumed are all zero, further
        // iterations cannot change the sum.
        if ((cnt_r == CNT_LAST) || ((mplier_r >> 1) == {WIDTH{1'b0}})) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
`else
        if (cnt_r == CNT_LAST) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
`endif
    end

    // Control FSM with registered busy/ready/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            square_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (start_i) begin
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CALC: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                    if (last_iter_s) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    // start_i is deliberately ignored here; a new start is
                    // only accepted once back in IDLE.
                    square_r <= acc_r;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Shift-and-add datapath: load on accepted start, one iteration per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        acc_r    <= {(2*WIDTH){1'b0}};
                        mcand_r  <= {{WIDTH{1'b0}}, valor_i};
                        mplier_r <= valor_i;
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        acc_r    <= acc_r;
                        mcand_r  <= mcand_r;
                        mplier_r <= mplier_r;
                        cnt_r    <= cnt_r;
                    end
                end
                CALC: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                default: begin
                    acc_r    <= acc_r;
                    mcand_r  <= mcand_r;
                    mplier_r <= mplier_r;
                    cnt_r    <= cnt_r;
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign ready_o  = ready_r;
    assign square_o = square_r;

endmodule

// File: tb/tb_squarer_seq.sv
// Scoreboard bench for squarer_seq: the stimulus side pushes the expected square
// and the expected ready_o cycle for every accepted start; an independent monitor
// pops and compares each time ready_o is seen.
module tb_squarer_seq;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [WIDTH-1:0]   valor_i;
    logic               busy_o;
    logic               ready_o;
    logic [2*WIDTH-1:0] square_o;

    typedef struct {
        int unsigned sq;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    squarer_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .valor_i  (valor_i),
        .start_i  (start_i),
        .busy_o   (busy_o),
        .ready_o  (ready_o),
        .square_o (square_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected ready_o pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference latency in clock edges from the accepting edge to the ready_o edge.
    function automatic int ref_latency(input int unsigned v);
`ifdef SQUARER_EARLY_EXIT_EN
        int hb;
        hb = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) hb = i;
        end
        return hb + 2;
`else
        return WIDTH + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && ready_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: got ready_o=1 square_o=%0d expected no pulse (cyc=%0d)",
                         square_o, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("square", square_o, e.sq);
                check("ready_cycle", cyc, e.cyc);
                check("busy_at_ready", busy_o, 1'b0);
            end
        end
    end

    // Issue one start in IDLE and record the expected response.
    task automatic do_op(input logic [WIDTH-1:0] v);
        int n;
        int unsigned vv;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", busy_o, 1'b0);
        vv      = v;
        e.sq    = vv * vv;
        e.cyc   = cyc + 1 + ref_latency(vv);
        sb_q.push_back(e);
        start_i = 1'b1;
        valor_i = v;
        @(negedge clk);
        start_i = 1'b0;
        valor_i = WIDTH'($urandom);
        check("busy_after_start", busy_o, 1'b1);
    endtask

    // Wait (bounded) until every expected result has been seen.
    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios, random operands and the exhaustive sweep.
    initial begin
        int lat7;
        int lat9;
        int c0;
        exp_t e;
        rst     = 1'b1;
        start_i = 1'b0;
        valor_i = {WIDTH{1'b0}};
        repeat (3) @(negedge clk);
        check("rst_square", square_o, 16'd0);
        check("rst_ready", ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valor_i = WIDTH'($urandom);
            @(negedge clk);
            check("idle_square", square_o, 16'd0);
            check("idle_busy", busy_o, 1'b0);
        end

        // Full-scale operand, then the zero and single-bit cases.
        do_op(8'd255);
        drain();
        do_op(8'd0);
        drain();
        do_op(8'd16);
        drain();

        // Start pulse during CALC must be ignored.
        do_op(8'd12);
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        valor_i = 8'd200;
        @(negedge clk);
        start_i = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        check("held_square_144", square_o, 16'd144);

        // Asynchronous reset in the middle of an operation.
        do_op(8'd200);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_square", square_o, 16'd0);
        check("midrst_ready", ready_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        do_op(8'd3);
        drain();

        // Back-to-back with start held high: 7 then 9.
        @(negedge clk);
        lat7    = ref_latency(7);
        lat9    = ref_latency(9);
        c0      = cyc + 1;
        e.sq    = 49;
        e.cyc   = c0 + lat7;
        sb_q.push_back(e);
        e.sq    = 81;
        e.cyc   = c0 + lat7 + 1 + lat9;
        sb_q.push_back(e);
        start_i = 1'b1;
        valor_i = 8'd7;
        @(negedge clk);
        valor_i = 8'd9;
        repeat (lat7 + 1) @(negedge clk);
        start_i = 1'b0;
        valor_i = WIDTH'($urandom);
        drain();

        // Random operands with random idle gaps.
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(3)) @(negedge clk);
            do_op(WIDTH'($urandom));
            drain();
        end

        // Exhaustive sweep.
        for (int x = 0; x < 256; x++) begin
            do_op(WIDTH'(x));
            drain();
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
